// File: rtl/boot_button_ctrl.sv
// Warm-boot front end: synchronizes and debounces two buttons, steps the image
// number on "next" presses and fires a boot strobe after a long "boot" hold.
module boot_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOLD_CYCLES     = 12000000,
  parameter int BOOT_PULSE      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_boot,
  output logic       inc,
  output logic       select,
  output logic [1:0] image,
  output logic       armed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(BOOT_PULSE + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [PW-1:0] PULSE_MAX = PW'(BOOT_PULSE);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE, LOCK} StateT;

  // Bit 0 carries the "next" button, bit 1 the "boot" button.
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_stable;
  logic [1:0]    r_stablePrev;
  logic [DW-1:0] r_debCnt [2];

  // The stable level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta       <= '0;
      r_sync       <= '0;
      r_stable     <= '0;
      r_stablePrev <= '0;
      for (int i = 0; i < 2; i++) r_debCnt[i] <= '0;
    end else begin
      r_meta       <= {btn_boot, btn_next};
      r_sync       <= r_meta;
      r_stablePrev <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_stable[i] <= ~r_stable[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + DW'(1);
        end
      end
    end
  end

  logic w_nextRise;
  logic w_bootRise;
  logic w_bootFall;

  assign w_nextRise = r_stable[0] & ~r_stablePrev[0];
  assign w_bootRise = r_stable[1] & ~r_stablePrev[1];
  assign w_bootFall = ~r_stable[1] & r_stablePrev[1];

  StateT         r_state;
  StateT         w_state;
  logic [HW-1:0] r_holdCnt;
  logic [HW-1:0] w_holdCnt;
  logic [PW-1:0] r_pulseCnt;
  logic [PW-1:0] w_pulseCnt;
  logic          r_inc;
  logic          w_inc;
  logic          r_select;
  logic          w_select;
  logic [1:0]    r_image;
  logic [1:0]    w_image;
  logic          r_armed;
  logic          w_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_holdCnt  <= '0;
      r_pulseCnt <= '0;
      r_inc      <= 1'b0;
      r_select   <= 1'b0;
      r_image    <= 2'd0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_holdCnt  <= w_holdCnt;
      r_pulseCnt <= w_pulseCnt;
      r_inc      <= w_inc;
      r_select   <= w_select;
      r_image    <= w_image;
      r_armed    <= w_armed;
    end
  end

  // Outputs are computed here and registered above, so select is glitch-free.
  always_comb begin
    w_state    = r_state;
    w_holdCnt  = r_holdCnt;
    w_pulseCnt = r_pulseCnt;
    w_inc      = 1'b0;
    w_select   = r_select;
    w_image    = r_image;
    w_armed    = r_armed;
    case (r_state)
      IDLE: begin
        if (w_bootRise) begin
          w_state   = ARMED;
          w_holdCnt = '0;
          w_armed   = 1'b1;
        end else if (w_nextRise) begin
          w_inc   = 1'b1;
          w_image = r_image + 2'd1;
        end
      end
      ARMED: begin
        if (w_bootFall) begin
          w_state = IDLE;
          w_armed = 1'b0;
        end else if (r_holdCnt == HOLD_MAX) begin
          w_state    = FIRE;
          w_armed    = 1'b0;
          w_select   = 1'b1;
          w_pulseCnt = PW'(1);
        end else if (r_stable[1] && (r_holdCnt < HOLD_MAX)) begin
          w_holdCnt = r_holdCnt + HW'(1);
        end
      end
      FIRE: begin
        if (r_pulseCnt == PULSE_MAX) begin
          w_state  = LOCK;
          w_select = 1'b0;
        end else begin
          w_pulseCnt = r_pulseCnt + PW'(1);
        end
      end
      LOCK: begin
        w_state = LOCK;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign inc    = r_inc;
  assign select = r_select;
  assign image  = r_image;
  assign armed  = r_armed;

endmodule

// File: tb/tb_boot_button_ctrl.sv
// Bench for boot_button_ctrl: a timestamp/window model of the button rules is
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_boot_button_ctrl;

  localparam int DEB   = 4;
  localparam int HOLD  = 16;
  localparam int PULSE = 3;
  localparam int MAXC  = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_boot;
  logic       inc;
  logic       select;
  logic [1:0] image;
  logic       armed;

  always #5 clk = ~clk;

  boot_button_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .BOOT_PULSE(PULSE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_boot(btn_boot),
    .inc(inc),
    .select(select),
    .image(image),
    .armed(armed)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: raw samples per edge; a debounced level flips once the synchronized
  // samples (two edges old) have shown the opposite level for DEB edges since reset.
  int cyc = 0;
  bit rawN [MAXC];
  bit rawB [MAXC];
  int lastReset = -1000;
  bit modelReady = 1'b0;
  bit dN, dNp, dB, dBp;
  int armedAt = -1;
  int fireAt = -1;
  int mImage = 0;
  bit expInc, expSelect, expArmed;

  function automatic bit sampleAt(input bit which, input int idx);
    if (idx < 0 || idx >= MAXC) return 1'b0;
    return which ? rawB[idx] : rawN[idx];
  endfunction

  function automatic bit windowFlip(input bit which, input int n, input bit level);
    if (n - DEB + 1 <= lastReset) return 1'b0;
    for (int k = 0; k < DEB; k++)
      if (sampleAt(which, n - 2 - k) == level) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit riseN, riseB, fallB, newN, newB;
    if (cyc < MAXC) begin
      rawN[cyc] = btn_next;
      rawB[cyc] = btn_boot;
    end
    if (rst) begin
      lastReset = cyc;
      if (cyc < MAXC) begin
        rawN[cyc] = 1'b0;
        rawB[cyc] = 1'b0;
      end
      if (cyc > 0 && cyc <= MAXC) begin
        rawN[cyc-1] = 1'b0;
        rawB[cyc-1] = 1'b0;
      end
      dN = 0; dNp = 0; dB = 0; dBp = 0;
      armedAt = -1; fireAt = -1; mImage = 0;
      expInc = 0; expSelect = 0; expArmed = 0;
      modelReady = 1'b1;
    end else begin
      riseN = dN && !dNp;
      riseB = dB && !dBp;
      fallB = !dB && dBp;
      expInc = 1'b0;
      if (fireAt >= 0) begin
        // firing or locked: buttons have no effect
      end else if (armedAt >= 0) begin
        if (fallB) armedAt = -1;
        else if (cyc == armedAt + HOLD + 1) begin
          fireAt = cyc;
          armedAt = -1;
        end
      end else if (riseB) begin
        armedAt = cyc;
      end else if (riseN) begin
        expInc = 1'b1;
        mImage = (mImage + 1) % 4;
      end
      expArmed  = (armedAt >= 0);
      expSelect = (fireAt >= 0) && (cyc < fireAt + PULSE);
      newN = windowFlip(1'b0, cyc, dN) ? !dN : dN;
      newB = windowFlip(1'b1, cyc, dB) ? !dB : dB;
      dNp = dN; dN = newN;
      dBp = dB; dB = newB;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("incVsModel", inc, expInc);
      checkOutput("selectVsModel", select, expSelect);
      checkOutput("armedVsModel", armed, expArmed);
      checkOutput("imageVsModel", image, mImage);
    end
  end

  int incCount = 0;
  int selCount = 0;
  int armedCycles = 0;
  int armedRiseAt = -1;
  int selRiseAt = -1;
  bit armedLast = 1'b0;
  bit selLast = 1'b0;

  always @(negedge clk) begin
    incCount    += int'(inc);
    selCount    += int'(select);
    armedCycles += int'(armed);
    if (armed && !armedLast) armedRiseAt = cyc;
    if (select && !selLast) selRiseAt = cyc;
    armedLast = armed;
    selLast   = select;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit nextLvl, input bit bootLvl, input int n);
    btn_next = nextLvl;
    btn_boot = bootLvl;
    waitCycles(n);
  endtask

  task automatic doReset();
    rst = 1'b1;
    btn_next = 1'b0;
    btn_boot = 1'b0;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(1);
  endtask

  int baseInc, baseSel, baseArmed;
  int wrapImg [5] = '{1, 2, 3, 0, 1};
  bit seen;

  initial begin
    rst = 1'b1;
    btn_next = 1'b0;
    btn_boot = 1'b0;
    waitCycles(3);
    checkOutput("resetInc", inc, 0);
    checkOutput("resetSelect", select, 0);
    checkOutput("resetImage", image, 0);
    checkOutput("resetArmed", armed, 0);
    rst = 1'b0;
    waitCycles(1);

    // Clean press: inc exactly 7 edges after the raw rise
    baseInc = incCount;
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("cleanNoIncYet", inc, 0);
    waitCycles(1);
    checkOutput("cleanIncAt7", inc, 1);
    checkOutput("cleanImage", image, 1);
    checkOutput("modelImagePin", mImage, 1);
    waitCycles(1);
    checkOutput("cleanIncOneCycle", inc, 0);
    waitCycles(12);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("cleanIncCount", incCount - baseInc, 1);

    // Bounce: toggling every 2 cycles never debounces
    doReset();
    baseInc = incCount;
    for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("bounceIncCount", incCount - baseInc, 0);
    checkOutput("bounceImage", image, 0);

    // Wrap: five presses step 1,2,3,0,1
    doReset();
    baseInc = incCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 10);
      checkOutput("wrapImage", image, wrapImg[i]);
      applyStimulus(1'b0, 1'b0, 10);
    end
    checkOutput("wrapIncCount", incCount - baseInc, 5);
    checkOutput("modelWrapPin", mImage, 1);

    // Short boot: released before the hold completes
    doReset();
    baseSel = selCount;
    baseArmed = armedCycles;
    applyStimulus(1'b0, 1'b1, 12);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("shortArmedCycles", armedCycles - baseArmed, 12);
    checkOutput("shortNoSelect", selCount - baseSel, 0);
    checkOutput("shortArmedLow", armed, 0);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("shortBackToIdle", image, 1);

    // Long boot with a next press while armed, then presses in LOCK
    doReset();
    baseInc = incCount;
    baseSel = selCount;
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b0, 1'b1, 22);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("longSelectLatency", selRiseAt - armedRiseAt, 17);
    checkOutput("longSelectWidth", selCount - baseSel, 3);
    checkOutput("longNoIncArmed", incCount - baseInc, 0);
    checkOutput("longImageKept", image, 0);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 30);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("lockNoInc", incCount - baseInc, 0);
    checkOutput("lockNoSelect", selCount - baseSel, 3);
    checkOutput("lockArmedLow", armed, 0);

    // Reset during the second select cycle
    doReset();
    btn_boot = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      waitCycles(1);
      seen = select;
    end
    checkOutput("fireSelectSeen", seen, 1);
    waitCycles(1);
    checkOutput("fireSecondCycle", select, 1);
    rst = 1'b1;
    btn_boot = 1'b0;
    waitCycles(1);
    checkOutput("fireResetSelect", select, 0);
    checkOutput("fireResetImage", image, 0);
    checkOutput("fireResetArmed", armed, 0);
    rst = 1'b0;
    baseInc = incCount;
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("fireAfterInc", incCount - baseInc, 1);
    checkOutput("fireAfterImage", image, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
